// File: rtl/prog_updown_counter_pkg.sv
// Shared definitions for the programmable up/down counter family.
// Mode encodings are reused by the timebase and stopwatch blocks.
package prog_updown_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  // The reserved encoding behaves as wrap so that a stray value never stalls a timebase.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    return (raw == 2'd3) ? MODE_WRAP : mode_e'(raw);
  endfunction

endpackage

// File: rtl/prog_updown_counter.sv
// Up/down counter with a runtime limit, sync clear/load, wrap/saturate/one-shot
// terminal modes and a registered terminal-count pulse for cascading.
module prog_updown_counter
  import prog_updown_counter_pkg::*;
#(
  parameter int COUNTER_WIDTH = 4,
  parameter int RESET_MAX     = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE_IN,
  input  logic                     NEG_DIR_IN,
  input  logic [1:0]               MODE_IN,
  input  logic                     CLEAR_IN,
  input  logic                     LOAD_IN,
  input  logic [COUNTER_WIDTH-1:0] LOAD_VALUE_IN,
  input  logic                     MAX_WE_IN,
  input  logic [COUNTER_WIDTH-1:0] MAX_VALUE_IN,
  output logic                     TRIGG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT,
  output logic [COUNTER_WIDTH-1:0] MAX_OUT,
  output logic                     DONE_OUT,
  output logic                     ZERO_OUT
);

  localparam logic [COUNTER_WIDTH-1:0] MAX_INIT = COUNTER_WIDTH'(RESET_MAX);
  localparam logic [COUNTER_WIDTH-1:0] ONE      = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [COUNTER_WIDTH-1:0] max_q;
  logic [COUNTER_WIDTH-1:0] load_clamped;
  logic                     done_q, done_d;
  logic                     trigg_q, trigg_d;
  logic                     term;
  mode_e                    mode;

  // Up uses >= so a limit lowered beneath the count still terminates.
  always_comb begin
    mode         = decode_mode(MODE_IN);
    term         = NEG_DIR_IN ? (count_q == '0) : (count_q >= max_q);
    load_clamped = (LOAD_VALUE_IN > max_q) ? max_q : LOAD_VALUE_IN;
    count_d      = count_q;
    done_d       = done_q;
    trigg_d      = 1'b0;
    if (CLEAR_IN) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (LOAD_IN) begin
      count_d = load_clamped;
      done_d  = 1'b0;
    end else begin
      trigg_d = ENABLE_IN && term && !done_q;
      if (ENABLE_IN && !done_q) begin
        if (!term) begin
          count_d = NEG_DIR_IN ? (count_q - ONE) : (count_q + ONE);
        end else begin
          case (mode)
            MODE_SAT:     count_d = count_q;
            MODE_ONESHOT: done_d  = 1'b1;
            default:      count_d = NEG_DIR_IN ? max_q : '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      max_q   <= MAX_INIT;
      done_q  <= 1'b0;
      trigg_q <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      trigg_q <= trigg_d;
      // Limit write sits outside the clear/load/count chain; same-cycle logic sees the old value.
      if (MAX_WE_IN) max_q <= MAX_VALUE_IN;
    end
  end

  assign COUNT     = count_q;
  assign MAX_OUT   = max_q;
  assign DONE_OUT  = done_q;
  assign TRIGG_OUT = trigg_q;
  assign ZERO_OUT  = (count_q == '0);

endmodule

// File: tb/tb_prog_updown_counter.sv
// Directed bench for prog_updown_counter: per-cycle comparison against an
// arithmetic model plus hand-computed checkpoints from the test plan.
module tb_prog_updown_counter;

  localparam int W    = 4;
  localparam int RMAX = 9;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, dir = 1'b0, clr = 1'b0, ld = 1'b0, we = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] lv = '0, mv = '0;
  logic         trigg, done, zero;
  logic [W-1:0] count, max_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;
  int tr_cnt = 0;
  int last_trig_count = -1;

  // Behavioural model state
  int m_count, m_max;
  bit m_trigg, m_done;

  prog_updown_counter #(.COUNTER_WIDTH(W), .RESET_MAX(RMAX)) dut (
    .CLK(clk), .RESET(rst), .ENABLE_IN(en), .NEG_DIR_IN(dir), .MODE_IN(mode),
    .CLEAR_IN(clr), .LOAD_IN(ld), .LOAD_VALUE_IN(lv), .MAX_WE_IN(we),
    .MAX_VALUE_IN(mv), .TRIGG_OUT(trigg), .COUNT(count), .MAX_OUT(max_o),
    .DONE_OUT(done), .ZERO_OUT(zero)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Model: the rules applied with integer arithmetic on pre-edge values.
  always @(posedge clk or posedge rst) begin
    int c, lim, md, nc;
    bit t, nd, ntr;
    if (rst) begin
      m_count <= 0;
      m_max   <= RMAX;
      m_trigg <= 1'b0;
      m_done  <= 1'b0;
    end else begin
      c   = m_count;
      lim = m_max;
      md  = (int'(mode) == 3) ? 0 : int'(mode);
      t   = dir ? (c == 0) : (c >= lim);
      nc  = c;
      nd  = m_done;
      ntr = 1'b0;
      if (clr) begin
        nc = 0; nd = 1'b0;
      end else if (ld) begin
        nc = (int'(lv) < lim) ? int'(lv) : lim;
        nd = 1'b0;
      end else begin
        ntr = en && t && !m_done;
        if (en && !m_done) begin
          if (!t)            nc = dir ? c - 1 : c + 1;
          else if (md == 0)  nc = dir ? lim : 0;
          else if (md == 2)  nd = 1'b1;
        end
      end
      m_count <= nc % (1 << W);
      m_done  <= nd;
      m_trigg <= ntr;
      if (we) m_max <= int'(mv);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", 32'(count), 32'(m_count));
      chk("max",   32'(max_o), 32'(m_max));
      chk("trigg", 32'(trigg), 32'(m_trigg));
      chk("done",  32'(done),  32'(m_done));
      chk("zero",  32'(zero),  32'(m_count == 0));
    end
    if (trigg === 1'b1) begin
      tr_cnt++;
      last_trig_count = int'(count);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic d, input logic [1:0] m,
                       input logic c, input logic l, input logic [W-1:0] lval,
                       input logic w, input logic [W-1:0] mval);
    en = e; dir = d; mode = m; clr = c; ld = l; lv = lval; we = w; mv = mval;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int tr0;

  initial begin
    // Reset state, checked without any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_max",   32'(max_o), 32'd9);
    chk("rst_trigg", 32'(trigg), 32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_zero",  32'(zero),  32'd1);
    #1 rst = 1'b0;
    check_en = 1'b1;

    // Wrap up, limit 9: 0..9,0,1 with one pulse while COUNT shows 0
    tr0 = tr_cnt;
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
    run(11);
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_up_count", 32'(count), 32'd1);
    chk("wrap_up_pulses", 32'(tr_cnt - tr0), 32'd1);
    chk("wrap_up_pulse_at", 32'(last_trig_count), 32'd0);

    // Wrap down from 0: 9,8,7 with one pulse after the 0->9 step
    drive(0, 0, 2'd0, 1, 0, 0, 0, 0);
    tick();
    tr0 = tr_cnt;
    drive(1, 1, 2'd0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_dn_first", 32'(count), 32'd9);
    chk("wrap_dn_trigg", 32'(trigg), 32'd1);
    run(2);
    chk("wrap_dn_count", 32'(count), 32'd7);
    // Async reset mid-sequence, no clock edge in between
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_trigg", 32'(trigg), 32'd0);
    rst = 1'b0;
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
    tick();

    // Saturate, limit 5, 10 enabled cycles: parks at 5, pulses on 5 cycles
    drive(0, 0, 2'd1, 0, 0, 0, 1, 5);
    tick();
    tr0 = tr_cnt;
    drive(1, 0, 2'd1, 0, 0, 0, 0, 0);
    run(10);
    drive(0, 0, 2'd1, 0, 0, 0, 0, 0);
    tick();
    chk("sat_count", 32'(count), 32'd5);
    chk("sat_pulses", 32'(tr_cnt - tr0), 32'd5);
    chk("sat_trigg_off", 32'(trigg), 32'd0);

    // One-shot, limit 3: single pulse, DONE, further enables ignored
    drive(0, 0, 2'd2, 1, 0, 0, 1, 3);
    tick();
    tr0 = tr_cnt;
    drive(1, 0, 2'd2, 0, 0, 0, 0, 0);
    run(8);
    chk("os_count", 32'(count), 32'd3);
    chk("os_done", 32'(done), 32'd1);
    chk("os_pulses", 32'(tr_cnt - tr0), 32'd1);
    // Mode change does not clear DONE
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
    run(2);
    chk("os_mode_chg_done", 32'(done), 32'd1);
    chk("os_mode_chg_count", 32'(count), 32'd3);
    drive(1, 0, 2'd2, 0, 1, 1, 0, 0);
    tick();
    chk("os_rearm_count", 32'(count), 32'd1);
    chk("os_rearm_done", 32'(done), 32'd0);
    drive(1, 0, 2'd2, 0, 0, 0, 0, 0);
    tick();
    chk("os_resume", 32'(count), 32'd2);

    // Limit reprogramming: step at 7 uses old limit 9, next step sees 8>=4
    drive(0, 0, 2'd0, 0, 0, 0, 1, 9);
    tick();
    drive(0, 0, 2'd0, 0, 1, 7, 0, 0);
    tick();
    drive(1, 0, 2'd0, 0, 0, 0, 1, 4);
    tick();
    chk("reprog_count", 32'(count), 32'd8);
    chk("reprog_max", 32'(max_o), 32'd4);
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
    tick();
    chk("reprog_wrap", 32'(count), 32'd0);
    chk("reprog_trigg", 32'(trigg), 32'd1);

    // Simultaneous clear+load+enable, then clamped load
    drive(0, 0, 2'd0, 0, 0, 0, 1, 9);
    tick();
    drive(0, 0, 2'd0, 0, 1, 5, 0, 0);
    tick();
    drive(1, 0, 2'd0, 1, 1, 3, 0, 0);
    tick();
    chk("simul_count", 32'(count), 32'd0);
    chk("simul_trigg", 32'(trigg), 32'd0);
    drive(0, 0, 2'd0, 0, 1, 12, 0, 0);
    tick();
    chk("clamp_count", 32'(count), 32'd9);

    // Mode 3 behaves as wrap; then down from 9 and direction flip mid-count
    drive(1, 0, 2'd3, 0, 0, 0, 0, 0);
    tick();
    chk("mode3_wrap", 32'(count), 32'd0);
    chk("mode3_trigg", 32'(trigg), 32'd1);
    drive(1, 0, 2'd0, 0, 0, 0, 0, 0);
    run(3);
    drive(1, 1, 2'd0, 0, 0, 0, 0, 0);
    run(2);
    chk("dir_flip", 32'(count), 32'd1);
    drive(1, 1, 2'd1, 0, 0, 0, 0, 0);
    run(3);
    chk("sat_down", 32'(count), 32'd0);
    drive(0, 0, 2'd0, 0, 0, 0, 0, 0);
    run(2);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
